// File: rtl/oddr_gearbox_ctrl.sv
// oddr_gearbox_ctrl
// Start-up and re-alignment sequencer for an output DDR serializer bank.
// After PLL lock has been stable for LOCK_CNT cycles it stops the edge
// clock, pulses the serializer reset, restarts the edge clock, optionally
// sends a block of training words, and then forwards user data.
//
// Build option:
//   ODDR_GBX_CTRL_TRAIN_EN  defined   -> TRAIN state sends TRAIN_WORDS x TRAIN_PAT
//                           undefined -> STOP2 goes straight to RUN
//
// Ports:
//   i_sclk      parallel clock, all logic on its rising edge
//   i_rst       synchronous active-high reset
//   i_lock      PLL lock (already in the i_sclk domain)
//   i_resync    one-cycle request to re-run alignment (TRAIN/RUN only)
//   i_din       user word, bit 0 transmitted first
//   o_dout      word to serializer D0..D15
//   o_ecstop    high stops the edge clock to the serializer bank
//   o_ddr_rst   serializer bank reset
//   o_ready     high while o_dout carries user data
//   o_state     current state encoding
module oddr_gearbox_ctrl #(
  parameter int          LOCK_CNT    = 16,
  parameter int          STOP_CYC    = 4,
  parameter int          RST_CYC     = 4,
  parameter int          TRAIN_WORDS = 64,
  parameter logic [15:0] TRAIN_PAT   = 16'h00FF
) (
  input  logic        i_sclk,
  input  logic        i_rst,
  input  logic        i_lock,
  input  logic        i_resync,
  input  logic [15:0] i_din,
  output logic [15:0] o_dout,
  output logic        o_ecstop,
  output logic        o_ddr_rst,
  output logic        o_ready,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STOP1     = 3'd1,
    GBX_RST   = 3'd2,
    STOP2     = 3'd3,
    TRAIN     = 3'd4,
    RUN       = 3'd5
  } state_t;

  // One shared phase counter, sized for the longest phase.
  localparam int MAX_A = (LOCK_CNT > STOP_CYC)    ? LOCK_CNT : STOP_CYC;
  localparam int MAX_B = (RST_CYC  > TRAIN_WORDS) ? RST_CYC  : TRAIN_WORDS;
  localparam int MAX_P = (MAX_A    > MAX_B)       ? MAX_A    : MAX_B;
  localparam int CW    = $clog2(MAX_P + 1);

  // A phase ends on the edge where the counter shows its last cycle.
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYC - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_dout;
  logic          r_ecstop;
  logic          r_ddr_rst;
  logic          r_ready;

  state_t        w_nxt;
  logic          w_resync_ok;
  logic [15:0]   w_train_word;

`ifdef ODDR_GBX_CTRL_TRAIN_EN
  localparam logic [CW-1:0] TRAIN_LAST = CW'(TRAIN_WORDS - 1);
  assign w_resync_ok  = (r_state == TRAIN) || (r_state == RUN);
  assign w_train_word = TRAIN_PAT;
`else
  // Training is compiled out; the pattern is deliberately not consumed.
  logic w_unused_pat;
  assign w_unused_pat = ^TRAIN_PAT;
  assign w_resync_ok  = (r_state == RUN);
  assign w_train_word = 16'h0000;
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      WAIT_LOCK: if (i_lock && r_cnt == LOCK_LAST) w_nxt = STOP1;
      STOP1:     if (r_cnt == STOP_LAST)           w_nxt = GBX_RST;
      GBX_RST:   if (r_cnt == RST_LAST)            w_nxt = STOP2;
`ifdef ODDR_GBX_CTRL_TRAIN_EN
      STOP2:     if (r_cnt == STOP_LAST)           w_nxt = TRAIN;
      TRAIN:     if (r_cnt == TRAIN_LAST)          w_nxt = RUN;
`else
      STOP2:     if (r_cnt == STOP_LAST)           w_nxt = RUN;
`endif
      RUN:       w_nxt = RUN;
      default:   w_nxt = WAIT_LOCK;
    endcase
    // Lock loss outranks a resync request arriving on the same cycle.
    if (r_state != WAIT_LOCK && !i_lock) w_nxt = WAIT_LOCK;
    else if (i_resync && w_resync_ok)    w_nxt = STOP1;
  end

  // Outputs are decoded from the next state so they move on the same edge
  // as the state register.
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_state   <= WAIT_LOCK;
      r_cnt     <= '0;
      r_dout    <= 16'h0000;
      r_ecstop  <= 1'b0;
      r_ddr_rst <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state)
        r_cnt <= '0;
      else if (r_state == WAIT_LOCK && !i_lock)
        r_cnt <= '0;                 // lock run must be consecutive
      else if (r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;       // saturate, never wrap

      r_ecstop  <= (w_nxt == STOP1) || (w_nxt == GBX_RST) || (w_nxt == STOP2);
      r_ddr_rst <= (w_nxt == WAIT_LOCK) || (w_nxt == STOP1) || (w_nxt == GBX_RST);
      r_ready   <= (w_nxt == RUN);
      if (w_nxt == RUN)        r_dout <= i_din;
      else if (w_nxt == TRAIN) r_dout <= w_train_word;
      else                     r_dout <= 16'h0000;
    end
  end

  assign o_state   = r_state;
  assign o_dout    = r_dout;
  assign o_ecstop  = r_ecstop;
  assign o_ddr_rst = r_ddr_rst;
  assign o_ready   = r_ready;

endmodule

// File: tb/tb_oddr_gearbox_ctrl.sv
// Testbench for oddr_gearbox_ctrl: directed sequences plus randomized
// lock/resync/reset traffic, checked against a timeline model through a
// scoreboard queue.
module tb_oddr_gearbox_ctrl;

  localparam int          LC  = 16;
  localparam int          SC  = 4;
  localparam int          RC  = 4;
  localparam int          TW  = 64;
  localparam logic [15:0] PAT = 16'h00FF;

`ifdef ODDR_GBX_CTRL_TRAIN_EN
  localparam int EXP_READY = 92;
  localparam int EXP_PAT   = 64;
`else
  localparam int EXP_READY = 28;
  localparam int EXP_PAT   = 0;
`endif

  logic        clk = 1'b0;
  logic        i_rst = 1'b0, i_lock = 1'b0, i_resync = 1'b0;
  logic [15:0] i_din = 16'h0;
  logic [15:0] o_dout;
  logic        o_ecstop, o_ddr_rst, o_ready;
  logic [2:0]  o_state;

  always #5 clk = ~clk;

  oddr_gearbox_ctrl #(
    .LOCK_CNT(LC), .STOP_CYC(SC), .RST_CYC(RC), .TRAIN_WORDS(TW), .TRAIN_PAT(PAT)
  ) dut (
    .i_sclk(clk), .i_rst(i_rst), .i_lock(i_lock), .i_resync(i_resync),
    .i_din(i_din), .o_dout(o_dout), .o_ecstop(o_ecstop),
    .o_ddr_rst(o_ddr_rst), .o_ready(o_ready), .o_state(o_state)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @edge %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Reference model: where are we on the timeline since the last STOP1 entry?
  bit m_seq = 1'b0;
  int m_run = 0;
  int m_t   = 0;

  function automatic int phase(input int t);
    if (t < SC)           return 1;
    if (t < SC + RC)      return 2;
    if (t < 2*SC + RC)    return 3;
`ifdef ODDR_GBX_CTRL_TRAIN_EN
    if (t < 2*SC + RC + TW) return 4;
`endif
    return 5;
  endfunction

  logic [21:0] q[$];   // {state, ecstop, ddr_rst, ready, dout}

  task automatic step(input logic rst, input logic lock, input logic resync,
                      input logic [15:0] din);
    int st;
    logic [15:0] d;
    @(negedge clk);
    i_rst = rst; i_lock = lock; i_resync = resync; i_din = din;
    if (rst) begin
      m_seq = 1'b0; m_run = 0;
    end else if (!m_seq) begin
      if (lock) begin
        m_run++;
        if (m_run >= LC) begin m_seq = 1'b1; m_t = 0; m_run = 0; end
      end else m_run = 0;
    end else if (!lock) begin
      m_seq = 1'b0; m_run = 0;
    end else if (resync && phase(m_t) >= 4) begin
      m_t = 0;
    end else if (m_t < 1000000) begin
      m_t++;
    end
    st = m_seq ? phase(m_t) : 0;
    d  = (st == 5) ? din : (st == 4) ? PAT : 16'h0000;
    q.push_back({3'(st), (st >= 1 && st <= 3), (st <= 2), (st == 5), d});
    @(posedge clk);
    cyc++;
    #2;
  endtask

  // Monitor: outputs are valid every cycle, one expectation per edge.
  initial begin
    logic [21:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb", {10'h0, o_state, o_ecstop, o_ddr_rst, o_ready, o_dout}, {10'h0, e});
      end
    end
  end

  task automatic run_to_ready();
    for (int k = 0; k < 300 && !o_ready; k++) step(1'b0, 1'b1, 1'b0, 16'($urandom));
    chk("reach_run", o_ready, 1'b1);
  endtask

  initial begin
    int ec_rise, dr_fall, ec_fall, rdy_rise, pat_cnt;

    // Reset state, then lock held high from the reset edge.
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("rst_state", o_state, 3'd0);
    chk("rst_ddr",   o_ddr_rst, 1'b1);
    chk("rst_ec",    o_ecstop, 1'b0);
    chk("rst_rdy",   o_ready, 1'b0);
    chk("rst_dout",  o_dout, 16'h0);

    ec_rise = -1; dr_fall = -1; ec_fall = -1; rdy_rise = -1; pat_cnt = 0;
    for (int n = 1; n <= 100; n++) begin
      step(1'b0, 1'b1, 1'b0, 16'($urandom));
      if (o_ecstop && ec_rise < 0)                   ec_rise = n;
      if (!o_ddr_rst && dr_fall < 0)                 dr_fall = n;
      if (!o_ecstop && ec_rise >= 0 && ec_fall < 0)  ec_fall = n;
      if (o_ready && rdy_rise < 0)                   rdy_rise = n;
      if (!o_ready && o_dout == PAT)                 pat_cnt++;
    end
    chk("ec_rise_cyc",  ec_rise, 16);
    chk("ddr_fall_cyc", dr_fall, 24);
    chk("ec_fall_cyc",  ec_fall, 28);
    chk("ready_cyc",    rdy_rise, EXP_READY);
    chk("train_words",  pat_cnt, EXP_PAT);

    // Data forwarding latency and lock loss in RUN.
    step(1'b0, 1'b1, 1'b0, 16'hA5C3);
    chk("run_dout", o_dout, 16'hA5C3);
    step(1'b0, 1'b0, 1'b0, 16'h1234);
    chk("lol_state", o_state, 3'd0);
    chk("lol_rdy",   o_ready, 1'b0);
    chk("lol_dout",  o_dout, 16'h0);
    chk("lol_ddr",   o_ddr_rst, 1'b1);

    // Lock glitch at count 10 restarts the count.
    step(1'b1, 1'b1, 1'b0, 16'h0);
    for (int n = 0; n < 10; n++) step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    for (int n = 0; n < 15; n++) step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("glitch_wait", o_state, 3'd0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("glitch_stop1", o_state, 3'd1);

    // Resync vs lock loss priority, then resync alone.
    run_to_ready();
    step(1'b0, 1'b0, 1'b1, 16'h0);
    chk("resync_lol", o_state, 3'd0);
    run_to_ready();
    step(1'b0, 1'b1, 1'b1, 16'h0);
    chk("resync_state", o_state, 3'd1);
    chk("resync_ec",    o_ecstop, 1'b1);

    // Reset in the middle of GBX_RST.
    step(1'b1, 1'b1, 1'b0, 16'h0);
    for (int n = 0; n < 20; n++) step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("in_gbx", o_state, 3'd2);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("gbx_rst_state", o_state, 3'd0);
    chk("gbx_rst_ec",    o_ecstop, 1'b0);
    for (int n = 0; n < 16; n++) step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("gbx_rst_relock", o_state, 3'd1);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++)
      step($urandom_range(0, 599) == 0, $urandom_range(0, 249) != 0,
           $urandom_range(0, 79) == 0, 16'($urandom));

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/oddr_gearbox_ctrl.md
ODDR_GEARBOX_CTRL -- requirements
Module: oddr_gearbox_ctrl

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 16, consecutive LOCK-high SCLK cycles required before sequencing.
REQ-002 SHALL have parameter STOP_CYC, default 4, SCLK cycles ECSTOP is held before and after DDR_RST.
REQ-003 SHALL have parameter RST_CYC, default 4, SCLK cycles DDR_RST is held high.
REQ-004 SHALL have parameter TRAIN_WORDS, default 64, training words issued before READY.
REQ-005 SHALL have parameter TRAIN_PAT, default 16'h00FF, 16-bit training word.
REQ-006 SHALL have SCLK  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have RST  input  1  reset, synchronous, active-high.
REQ-008 SHALL have LOCK  input  1  PLL lock, already synchronous to SCLK.
REQ-009 SHALL have RESYNC  input  1  single-cycle request to re-run the gearbox alignment sequence.
REQ-010 SHALL have DIN  input  16  user parallel word, bit 0 transmitted first.
REQ-011 SHALL have DOUT  output  16  word driving serializer D0..D15.
REQ-012 SHALL have ECSTOP  output  1  high stops the edge clock to the serializer bank.
REQ-013 SHALL have DDR_RST  output  1  reset to the serializer bank.
REQ-014 SHALL have READY  output  1  high while DOUT carries user data.
REQ-015 SHALL have STATE  output  3  current FSM state encoding.

Function
REQ-016 FSM states/encodings SHALL be WAIT_LOCK=0, STOP1=1, GBX_RST=2, STOP2=3, TRAIN=4, RUN=5; 6,7 unreachable and SHALL return to WAIT_LOCK.
REQ-017 WAIT_LOCK: DDR_RST=1, ECSTOP=0; lock counter increments while LOCK=1, clears on LOCK=0; on reaching LOCK_CNT SHALL go to STOP1.
REQ-018 STOP1: ECSTOP=1, DDR_RST=1 for STOP_CYC cycles, then GBX_RST.
REQ-019 GBX_RST: ECSTOP=1, DDR_RST=1 for RST_CYC cycles, then STOP2.
REQ-020 STOP2: ECSTOP=1, DDR_RST=0 for STOP_CYC cycles, then TRAIN.
REQ-021 TRAIN: ECSTOP=0, DDR_RST=0, DOUT=TRAIN_PAT for exactly TRAIN_WORDS cycles, then RUN.
REQ-022 RUN: READY=1, DOUT=DIN registered (1 SCLK latency from DIN to DOUT).
REQ-023 DOUT SHALL be 16'h0000 in WAIT_LOCK, STOP1, GBX_RST, STOP2.
REQ-024 All outputs SHALL be registered; STATE, ECSTOP, DDR_RST, READY change on the same edge as the state transition.
REQ-025 LOCK=0 in any state other than WAIT_LOCK SHALL force WAIT_LOCK on the next edge with lock counter cleared.
REQ-026 RESYNC=1 in TRAIN or RUN SHALL go to STOP1; RESYNC in other states SHALL be ignored.
REQ-027 Simultaneous LOCK=0 and RESYNC=1: LOCK loss SHALL win (WAIT_LOCK).
REQ-028 Phase counters SHALL clear on every state entry; counters SHALL saturate, never wrap; width SHALL fit the largest parameter.

Reset
REQ-029 RST=1 at a rising SCLK edge SHALL set STATE=WAIT_LOCK, DDR_RST=1, ECSTOP=0, READY=0, DOUT=16'h0000, all counters 0, regardless of current state.
REQ-030 RST asserted mid-sequence or mid-RUN SHALL abort immediately with no further DIN forwarded.

Configuration
REQ-031 Macro ODDR_GBX_CTRL_TRAIN_EN defined: TRAIN state SHALL exist as in REQ-021.
REQ-032 Macro ODDR_GBX_CTRL_TRAIN_EN undefined: STOP2 SHALL go directly to RUN, state 4 SHALL be unreachable, TRAIN_WORDS/TRAIN_PAT SHALL be unused.

Verification
REQ-033 RST then LOCK=1 held, defaults, TRAIN_EN defined -> ECSTOP rises at cycle 16, DDR_RST falls at cycle 24, ECSTOP falls at cycle 28, TRAIN_PAT for 64 cycles, READY=1 at cycle 92.
REQ-034 LOCK toggles low at lock count 10 -> counter clears; STOP1 entered only after 16 further consecutive high cycles.
REQ-035 In RUN drive DIN=16'hA5C3 -> DOUT=16'hA5C3 one cycle later; LOCK=0 -> next edge STATE=0, READY=0, DOUT=0, DDR_RST=1.
REQ-036 In RUN pulse RESYNC with LOCK=0 same cycle -> STATE=0, not 1; RESYNC alone -> STATE=1, ECSTOP=1.
REQ-037 RST pulse during GBX_RST -> next edge STATE=0, ECSTOP=0, counters 0.
REQ-038 TRAIN_EN undefined -> STATE goes 3 to 5 directly; READY=1 at cycle 28; state 4 never observed.
